// File: rtl/izh_neuron_array.sv
// Time-multiplexed Izhikevich neuron array: one shared fixed-point datapath
// sweeps every neuron once per tick, in index order, against local register files.
module izh_neuron_array #(
    parameter int N_NEURONS    = 4,
    parameter int V_WIDTH      = 16,
    parameter int FRAC         = 7,
    parameter int DT_SHIFT     = 4,
    parameter int REFRAC_TICKS = 2,
    localparam int IDX_W       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 cfg_we,
    output logic                 cfg_ready,
    input  logic [IDX_W-1:0]     cfg_addr,
    input  logic [2:0]           cfg_sel,
    input  logic [7:0]           cfg_data,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic                 spike_valid,
    output logic [IDX_W-1:0]     spike_idx,
    output logic [N_NEURONS-1:0] spike_vec,
    input  logic [IDX_W-1:0]     mon_idx,
    output logic [7:0]           mon_membrane
);

    localparam int XW = 2*V_WIDTH + 8;
    localparam int RW = (REFRAC_TICKS > 0) ? $clog2(REFRAC_TICKS + 1) : 1;

    localparam logic signed [XW-1:0] V_THR  = XW'(30 << FRAC);
    localparam logic signed [XW-1:0] V_REST = XW'(-(70 << FRAC));
    localparam logic signed [XW-1:0] K140   = XW'(140 << FRAC);
    localparam logic signed [XW-1:0] K5     = XW'(5);
    localparam logic signed [XW-1:0] K255   = XW'(255);
    localparam logic signed [XW-1:0] V_MAX  = {{(XW-V_WIDTH+1){1'b0}}, {(V_WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] V_MIN  = {{(XW-V_WIDTH+1){1'b1}}, {(V_WIDTH-1){1'b0}}};
    localparam logic signed [V_WIDTH-1:0] V_INIT = V_REST[V_WIDTH-1:0];
    localparam logic [RW-1:0]        REF_INIT = RW'(REFRAC_TICKS);
    localparam logic [IDX_W-1:0]     LAST     = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W:0]       N_IDX    = (IDX_W+1)'(N_NEURONS);

    typedef enum logic [1:0] {IDLE, FETCH, UPDATE, DONE} state_t;
    state_t state, state_nx;

    // per-neuron register files
    logic signed [V_WIDTH-1:0] v_mem    [N_NEURONS];
    logic signed [V_WIDTH-1:0] u_mem    [N_NEURONS];
    logic [RW-1:0]             rf_mem   [N_NEURONS];
    logic [7:0]                a_mem    [N_NEURONS];
    logic [7:0]                b_mem    [N_NEURONS];
    logic signed [7:0]         c_mem    [N_NEURONS];
    logic [7:0]                d_mem    [N_NEURONS];
    logic [7:0]                stim_mem [N_NEURONS];

    logic [IDX_W-1:0]          idx;
    logic [N_NEURONS-1:0]      spike_acc;

    logic signed [V_WIDTH-1:0] p_v, p_u;
    logic [RW-1:0]             p_rf;
    logic [7:0]                p_a, p_b, p_d, p_stim;
    logic signed [7:0]         p_c;

    function automatic logic signed [V_WIDTH-1:0] sat(input logic signed [XW-1:0] x);
        if (x > V_MAX) return V_MAX[V_WIDTH-1:0];
        if (x < V_MIN) return V_MIN[V_WIDTH-1:0];
        return x[V_WIDTH-1:0];
    endfunction

    // ---------------- update datapath ----------------
    logic signed [XW-1:0] vx, ux, ax, bx, sx, cx, dx;
    logic signed [XW-1:0] vsq, dv, du, nv, nu, us;
    logic signed [V_WIDTH-1:0] w_v, w_u;
    logic [RW-1:0]             w_rf;
    logic                      hit;

    assign vx = XW'(p_v);
    assign ux = XW'(p_u);
    assign ax = XW'(p_a);
    assign bx = XW'(p_b);
    assign sx = XW'(p_stim);
    assign dx = XW'(p_d);
    assign cx = XW'(p_c) <<< FRAC;

    always_comb begin
        vsq = (((vx * vx) >>> FRAC) * K5) >>> 7;
        dv  = vsq + K5 * vx + K140 - ux + (sx <<< FRAC);
        du  = (ax * (((bx * vx) >>> 8) - ux)) >>> 8;
        nv  = vx + (dv >>> DT_SHIFT);
        nu  = ux + (du >>> DT_SHIFT);
        us  = ux + (dx <<< FRAC);
        hit = (vx >= V_THR);
        w_v  = sat(nv);
        w_u  = sat(nu);
        w_rf = p_rf;
        if (hit) begin
            w_v  = sat(cx);
            w_u  = sat(us);
            w_rf = REF_INIT;
        end else if (p_rf != '0) begin
            // refractory: clamp at reset potential, skip integration entirely
            w_v  = sat(cx);
            w_u  = p_u;
            w_rf = p_rf - RW'(1);
        end
    end

    // ---------------- control ----------------
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign cfg_ready = !busy && !reset;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tick) state_nx = FETCH;
            FETCH:   state_nx = UPDATE;
            UPDATE:  state_nx = (idx == LAST) ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            overrun     <= 1'b0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            spike_acc   <= '0;
            spike_vec   <= '0;
            p_v         <= '0;
            p_u         <= '0;
            p_rf        <= '0;
            p_a         <= '0;
            p_b         <= '0;
            p_c         <= '0;
            p_d         <= '0;
            p_stim      <= '0;
        end else begin
            state       <= state_nx;
            spike_valid <= 1'b0;
            if (tick && busy) overrun <= 1'b1;
            case (state)
                IDLE: if (tick) begin
                    idx       <= '0;
                    spike_acc <= '0;
                end
                FETCH: begin
                    p_v    <= v_mem[idx];
                    p_u    <= u_mem[idx];
                    p_rf   <= rf_mem[idx];
                    p_a    <= a_mem[idx];
                    p_b    <= b_mem[idx];
                    p_c    <= c_mem[idx];
                    p_d    <= d_mem[idx];
                    p_stim <= stim_mem[idx];
                end
                UPDATE: begin
                    if (hit) begin
                        spike_valid    <= 1'b1;
                        spike_idx      <= idx;
                        spike_acc[idx] <= 1'b1;
                    end
                    idx <= idx + IDX_W'(1);
                end
                DONE: spike_vec <= spike_acc;
                default: ;
            endcase
        end
    end

    // ---------------- register files ----------------
    logic cfg_acc;
    assign cfg_acc = cfg_we && cfg_ready && ({1'b0, cfg_addr} < N_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i]    <= V_INIT;
                u_mem[i]    <= '0;
                rf_mem[i]   <= '0;
                stim_mem[i] <= '0;
                a_mem[i]    <= 8'd5;
                b_mem[i]    <= 8'd51;
                c_mem[i]    <= -8'sd65;
                d_mem[i]    <= 8'd8;
            end
        end else begin
            if (cfg_acc) begin
                case (cfg_sel)
                    3'd0: a_mem[cfg_addr]    <= cfg_data;
                    3'd1: b_mem[cfg_addr]    <= cfg_data;
                    3'd2: c_mem[cfg_addr]    <= cfg_data;
                    3'd3: d_mem[cfg_addr]    <= cfg_data;
                    3'd4: stim_mem[cfg_addr] <= cfg_data;
                    default: ;
                endcase
            end
            if (state == UPDATE) begin
                v_mem[idx]  <= w_v;
                u_mem[idx]  <= w_u;
                rf_mem[idx] <= w_rf;
            end
        end
    end

    // ---------------- membrane monitor ----------------
    logic                      mon_ok;
    logic signed [V_WIDTH-1:0] mon_v;
    logic signed [XW-1:0]      mon_off;
    logic [7:0]                mon_nx;

    always_comb begin
        mon_ok  = ({1'b0, mon_idx} < N_IDX);
        mon_v   = v_mem[mon_idx];
        // 2 counts per mV above rest
        mon_off = (XW'(mon_v) - V_REST) >>> (FRAC - 1);
        mon_nx  = 8'd0;
        if (!mon_ok)                    mon_nx = 8'd0;
        else if (XW'(mon_v) >= V_THR)   mon_nx = 8'hFF;
        else if (mon_off[XW-1])         mon_nx = 8'd0;
        else if (mon_off > K255)        mon_nx = 8'hFF;
        else                            mon_nx = mon_off[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) mon_membrane <= 8'd0;
        else       mon_membrane <= mon_nx;
    end

endmodule

// File: tb/tb_izh_neuron_array.sv
// Randomized bench for izh_neuron_array against a per-neuron arithmetic model of the sweep.
module tb_izh_neuron_array;
    localparam int N = 4;
    localparam int IW = 2;
    localparam int FRAC = 7;
    localparam int DT = 4;
    localparam int REF = 2;
    localparam longint S = 128;

    logic clk = 1'b0;
    logic reset, tick, cfg_we;
    logic [IW-1:0] cfg_addr, mon_idx;
    logic [2:0] cfg_sel;
    logic [7:0] cfg_data;
    logic cfg_ready, busy, done, overrun, spike_valid;
    logic [IW-1:0] spike_idx;
    logic [N-1:0] spike_vec;
    logic [7:0] mon_membrane;

    izh_neuron_array #(.N_NEURONS(N), .V_WIDTH(16), .FRAC(FRAC), .DT_SHIFT(DT), .REFRAC_TICKS(REF)) dut (
        .clk(clk), .reset(reset), .tick(tick), .cfg_we(cfg_we), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .busy(busy), .done(done),
        .overrun(overrun), .spike_valid(spike_valid), .spike_idx(spike_idx), .spike_vec(spike_vec),
        .mon_idx(mon_idx), .mon_membrane(mon_membrane)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint mv[N], mu[N];
    int mrf[N], ma[N], mb[N], mc[N], md[N], ms[N];
    logic [N-1:0] mmask;

    function automatic longint fl(input longint x, input int n);
        longint p;
        p = longint'(1) << n;
        if (x >= 0) return x / p;
        return -((-x + p - 1) / p);
    endfunction

    function automatic longint clampv(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic longint mon_model(input longint v);
        longint m;
        if (v >= 30 * S) return 255;
        m = fl(v + 70 * S, FRAC - 1);
        if (m < 0) return 0;
        if (m > 255) return 255;
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = -70 * S; mu[i] = 0; mrf[i] = 0; ms[i] = 0;
            ma[i] = 5; mb[i] = 51; mc[i] = -65; md[i] = 8;
        end
        mmask = '0;
    endtask

    task automatic model_sweep();
        longint v, u, dv, du;
        mmask = '0;
        for (int i = 0; i < N; i++) begin
            v = mv[i]; u = mu[i];
            if (v >= 30 * S) begin
                mv[i] = mc[i] * S; mu[i] = clampv(u + md[i] * S); mrf[i] = REF; mmask[i] = 1'b1;
            end else if (mrf[i] > 0) begin
                mv[i] = mc[i] * S; mrf[i] = mrf[i] - 1;
            end else begin
                dv = fl(fl(v * v, FRAC) * 5, 7) + 5 * v + 140 * S - u + ms[i] * S;
                du = fl(ma[i] * (fl(mb[i] * v, 8) - u), 8);
                mv[i] = clampv(v + fl(dv, DT));
                mu[i] = clampv(u + fl(du, DT));
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int sel, input int data);
        logic [7:0] d8;
        d8 = 8'(data);
        check("cfg_ready_idle", cfg_ready, 1);
        cfg_we = 1'b1; cfg_addr = IW'(addr); cfg_sel = 3'(sel); cfg_data = d8;
        step();
        cfg_we = 1'b0;
        case (sel)
            0: ma[addr] = int'(d8);
            1: mb[addr] = int'(d8);
            2: mc[addr] = int'($signed(d8));
            3: md[addr] = int'(d8);
            4: ms[addr] = int'(d8);
            default: ;
        endcase
    endtask

    task automatic compare_state(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s v[%0d]", tag, i), dut.v_mem[i], mv[i]);
            check($sformatf("%s u[%0d]", tag, i), dut.u_mem[i], mu[i]);
            check($sformatf("%s rf[%0d]", tag, i), dut.rf_mem[i], mrf[i]);
        end
    endtask

    // One sweep in a fixed, bounded window. At cycle inject_at a stray tick
    // plus a stimulus write are driven while the sweep is in progress.
    task automatic run_sweep(input int inject_at, input int inj_data);
        int dcnt, first, scnt;
        logic [N-1:0] seen;
        dcnt = 0; first = -1; scnt = 0; seen = '0;
        tick = 1'b1;
        for (int c = 1; c <= 2 * N + 4; c++) begin
            step();
            tick = 1'b0; cfg_we = 1'b0;
            if (done) begin dcnt++; if (first < 0) first = c; end
            if (spike_valid) begin scnt++; seen[spike_idx] = 1'b1; end
            if (c == inject_at) begin
                check("cfg_ready_busy", cfg_ready, 0);
                tick = 1'b1; cfg_we = 1'b1; cfg_sel = 3'd4; cfg_addr = 2'd2; cfg_data = 8'(inj_data);
            end
        end
        model_sweep();
        check("done_latency", first, 2 * N + 1);
        check("done_count", dcnt, 1);
        check("spike_mask", seen, mmask);
        check("spike_count", scnt, $countones(mmask));
        check("spike_vec", spike_vec, mmask);
        check("busy_after", busy, 0);
        compare_state("sweep");
    endtask

    task automatic mon_check(input int i);
        mon_idx = IW'(i);
        step();
        check($sformatf("mon[%0d]", i), mon_membrane, mon_model(mv[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int k;
        longint prev_u, hold_u;
        reset = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0; cfg_data = '0; mon_idx = '0;
        repeat (3) step();
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst overrun", overrun, 0);
        check("rst spike_valid", spike_valid, 0);
        check("rst spike_vec", spike_vec, 0);
        check("rst mon", mon_membrane, 0);
        check("rst cfg_ready", cfg_ready, 0);
        reset = 1'b0;
        model_reset();
        step();

        // first sweep from reset defaults
        run_sweep(-1, 0);
        for (int i = 0; i < N; i++) begin
            check("first v", dut.v_mem[i], -9109);
            check("first u", dut.u_mem[i], -3);
            mon_idx = IW'(i);
            step();
            check("first mon", mon_membrane, 0);
        end

        // drive neuron 1 to fire, then watch its refractory hold
        cfg_write(1, 4, 255);
        k = 0; prev_u = mu[1];
        while (!mmask[1] && k < 60) begin
            prev_u = mu[1];
            run_sweep(-1, 0);
            k++;
        end
        check("n1 fired", mmask[1], 1);
        check("n1 v reset", dut.v_mem[1], -8320);
        check("n1 u jump", dut.u_mem[1], prev_u + 1024);
        hold_u = mu[1];
        for (int r = 0; r < REF; r++) begin
            run_sweep(-1, 0);
            check("refrac v", dut.v_mem[1], -8320);
            check("refrac u", dut.u_mem[1], hold_u);
        end
        run_sweep(-1, 0);
        check("post refrac integrates", dut.v_mem[1] != -16'sd8320, 1);

        // random configuration and sweeps
        repeat (25) begin
            k = $urandom_range(0, 3);
            repeat (k) cfg_write($urandom_range(0, N - 1), $urandom_range(0, 7), $urandom_range(0, 255));
            run_sweep(-1, 0);
            mon_check($urandom_range(0, N - 1));
        end

        // stray tick and config write mid-sweep
        check("overrun clear", overrun, 0);
        run_sweep(3, 77);
        check("overrun set", overrun, 1);
        check("stim untouched", dut.stim_mem[2], ms[2]);
        run_sweep(-1, 0);
        check("overrun sticky", overrun, 1);

        // extreme parameters: saturation must hold without wrap
        cfg_write(0, 2, 127);
        cfg_write(0, 3, 255);
        cfg_write(0, 4, 255);
        cfg_write(3, 4, 255);
        cfg_write(3, 0, 255);
        repeat (200) begin
            run_sweep(-1, 0);
            mon_check(0);
        end

        // reset during FETCH of neuron 2
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (4) step();
        check("mid busy", busy, 1);
        reset = 1'b1;
        step();
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort overrun", overrun, 0);
        check("abort spike_valid", spike_valid, 0);
        check("abort spike_vec", spike_vec, 0);
        check("abort mon", mon_membrane, 0);
        model_reset();
        compare_state("abort");
        for (int i = 0; i < N; i++) begin
            check("abort a", dut.a_mem[i], ma[i]);
            check("abort b", dut.b_mem[i], mb[i]);
            check("abort c", dut.c_mem[i], mc[i]);
            check("abort d", dut.d_mem[i], md[i]);
            check("abort stim", dut.stim_mem[i], ms[i]);
        end
        reset = 1'b0;
        step();
        run_sweep(-1, 0);
        check("after abort v0", dut.v_mem[0], -9109);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/izh_neuron_array.md
Name: izh_neuron_array

Overview:
Time-multiplexed array of N_NEURONS Izhikevich neurons sharing one fixed-point update datapath. Per-neuron parameters (a, b, c, d), stimulus, and state (v, u, refractory count) are held in local register files. One global tick starts a sweep that updates every neuron once, in index order. The block sits between the parameter/stimulus configuration logic and the spike consumer, and is the multi-channel, widened, refractory-capable successor of the single-neuron core.

Parameters:
N_NEURONS, 4, neuron count (2..16); IDX_W = max(1, clog2(N_NEURONS))
V_WIDTH, 16, signed width of v and u (min 16)
FRAC, 7, fractional bits; scale S = 2^FRAC
DT_SHIFT, 4, integration step dt = 2^-DT_SHIFT
REFRAC_TICKS, 2, ticks a neuron is held at c after a spike (0 disables)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
tick  in  1  one-cycle pulse, starts a sweep
cfg_we  in  1  config write strobe
cfg_ready  out  1  high when a config write is accepted (= !busy)
cfg_addr  in  IDX_W  target neuron
cfg_sel  in  3  0=a, 1=b, 2=c, 3=d, 4=stimulus; 5-7 ignored
cfg_data  in  8  value; a, b, d, stimulus unsigned; c signed (mV)
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at end of sweep
overrun  out  1  sticky: a tick arrived while busy; cleared by reset only
spike_valid  out  1  one-cycle pulse when a neuron fires
spike_idx  out  IDX_W  index of the firing neuron
spike_vec  out  N_NEURONS  spikes of the last completed sweep
mon_idx  in  IDX_W  neuron selected for monitoring
mon_membrane  out  8  registered 8-bit membrane view of neuron mon_idx

Behaviour:
- Reset (synchronous, active-high; clock clk): all outputs 0.
- Reset loads every neuron with v = -70*S, u = 0, refrac = 0, stim = 0, and defaults a=5, b=51, c=-65, d=8.
- Reset aborts any in-progress sweep with no partial-write side effects beyond neurons already written.
- FSM states: IDLE, FETCH, UPDATE, DONE.
  - IDLE + tick -> FETCH with idx = 0; busy = 1.
  - FETCH: latch v, u, refrac, stim, and params for idx into pipeline registers -> UPDATE.
  - UPDATE: write back the new state; idx++ -> FETCH, or -> DONE after idx = N_NEURONS-1.
  - DONE: done = 1, spike_vec updated, busy = 0 -> IDLE.
  - Latency: done is high exactly 2*N_NEURONS+1 cycles after the tick cycle.
- A tick while busy is ignored and sets overrun. Ticks in the DONE cycle count as busy.
- Config: a write is accepted only when cfg_we && cfg_ready. Writes while busy are dropped, not queued. New values take effect on the next sweep.
- Update for one neuron (all arithmetic signed, intermediates at least 2*V_WIDTH+8 bits, arithmetic shifts floor):
  - If v >= 30*S: spike.
    - v' = c<<FRAC
    - u' = sat(u + (d<<FRAC))
    - refrac' = REFRAC_TICKS
    - spike_valid = 1, spike_idx = idx, spike_vec bit set
  - Else if refrac > 0: v' = c<<FRAC, u' = u, refrac' = refrac-1. No integration; stimulus ignored.
  - Else integrate:
    - dv = ((((v*v)>>>FRAC)*5)>>>7) + 5*v + 140*S - u + (stim<<FRAC)
    - du = (a*(((b*v)>>>8) - u))>>>8, with a and b in units of 1/256
    - v' = sat(v + (dv>>>DT_SHIFT)); u' = sat(u + (du>>>DT_SHIFT))
  - sat() clamps to the signed V_WIDTH range. No wrap-around is permitted.
- spike_vec is cleared at sweep start and accumulated internally. The output register updates only in DONE.
- mon_membrane (registered, one-cycle latency, continuous including when busy):
  - 0xFF if v >= 30*S
  - otherwise clamp((v + 70*S)>>>(FRAC-1), 0, 255), i.e. 2 counts per mV above -70 mV.
  - Reads state as last written.

Test Plan:
- Reset, no config -> one tick: done 9 cycles later (N=4). Every neuron has v = -9109, u = -3, mon_membrane = 0. No spike_valid; spike_vec = 0.
- Write stim=255 to neuron 1, tick repeatedly -> neuron 1 eventually fires: spike_valid with spike_idx = 1. Next sweep shows v = -8320 and u increased by 1024; neurons 0, 2, 3 never fire.
- Continue ticking after that spike (REFRAC_TICKS=2) -> the next 2 sweeps hold v = -8320 and u unchanged; the third sweep integrates.
- Pulse tick 3 cycles after a tick; cfg_we with cfg_sel=4 while busy -> overrun = 1 (sticky). Config is unchanged; still only one done.
- Set c = 127 and d = 255 with a large stimulus, run 200 ticks -> v and u stay within [-32768, 32767] with no sign flip; mon_membrane = 0xFF whenever v >= 3840.
- Assert reset during FETCH of neuron 2 -> next cycle busy = 0, outputs 0, all state and params at their reset defaults.
